// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial word receiver: counter sizing and output FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_rx_pkg;

  // Default word width used when no override is supplied.
  localparam int N_DEFAULT = 4;

  // Bit-counter width for a given word width (counts 0..n-1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_width(N_DEFAULT);

  // Output holding register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/serial_word_receiver_bit_collector.sv
// Collects an LSB-first serial stream into N-bit words; sync restarts word alignment.
// Latency: word_done/word are combinational in the cycle the Nth bit is strobed.
// Backpressure: none; bits are always accepted, the consumer must take word_done when it fires.
module bit_collector
  import serial_rx_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         serial_in,
  input  logic         shift_en,
  input  logic         sync,
  output logic         word_done,
  output logic [N-1:0] word,
  output logic         busy
);

  localparam int CW = cnt_width(N);

  logic [N-1:0]  r_sr;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last    = (r_cnt == CW'(N - 1));
  // Right shift: the newest bit enters at the MSB, so the first bit ends at word[0].
  assign word      = {serial_in, r_sr[N-1:1]};
  // A sync on the final bit position starts a new word instead of completing the old one.
  assign word_done = shift_en & ~sync & w_last;
  assign busy      = (r_cnt != '0);

  // Shift register and bit counter, with sync forcing realignment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (shift_en) begin
      r_sr <= word;
      if (sync) begin
        r_cnt <= CW'(1);
      end else if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (sync) begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Reassembles LSB-first serial bits into N-bit words held in a one-word output register.
// Latency: data_valid rises the cycle after the edge that samples the Nth bit.
// Backpressure: valid/ready; a word completing while the holder is full and unacknowledged is dropped and flags overrun.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         serial_in,
  input  logic         shift_en,
  input  logic         sync,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         overrun,
  input  logic         clr_overrun,
  output logic         busy
);

  out_state_t   r_state;
  out_state_t   w_state_nxt;
  logic [N-1:0] r_data;
  logic         r_ovr;
  logic         w_done;
  logic [N-1:0] w_word;
  logic         w_load;
  logic         w_ovr_set;

  bit_collector #(.N(N)) u_collector (
    .clk       (clk),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .shift_en  (shift_en),
    .sync      (sync),
    .word_done (w_done),
    .word      (w_word),
    .busy      (busy)
  );

  // Output FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, holder load and overrun detection; data_ready only matters when FULL.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_done) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_done && data_ready) begin
          w_load = 1'b1;
        end else if (w_done) begin
          w_ovr_set = 1'b1;
        end else if (data_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Holding register: only changes on a load, so it is stable while waiting for ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= w_word;
    end
  end

  // Sticky overrun; a new drop in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr <= 1'b0;
    end else if (w_ovr_set) begin
      r_ovr <= 1'b1;
    end else if (clr_overrun) begin
      r_ovr <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign data_valid = (r_state == ST_FULL);
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver (N=4): directed scenarios plus random traffic.
// A queue-based reference model predicts held words; a negedge monitor checks them.
// Both directed and monitor checks feed the same pass/fail counters.
module tb_serial_word_receiver;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         shift_en = 1'b0;
  logic         sync = 1'b0;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         overrun;
  logic         clr_overrun = 1'b0;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_word_receiver #(.N(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .serial_in   (serial_in),
    .shift_en    (shift_en),
    .sync        (sync),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit           mq[$];       // bits of the word in progress, oldest first
  logic [N-1:0] exp_q[$];    // words that entered the holder, in order
  bit           m_vld;
  bit           m_ovr;

  always @(posedge clk or negedge reset_n) begin
    bit           done;
    bit           hs;
    logic [N-1:0] w;
    if (!reset_n) begin
      mq.delete();
      exp_q.delete();
      m_vld = 0;
      m_ovr = 0;
    end else begin
      done = 0;
      w    = '0;
      if (shift_en) begin
        if (sync) begin
          mq.delete();
          mq.push_back(serial_in);
        end else begin
          mq.push_back(serial_in);
          if (mq.size() == N) begin
            for (int i = 0; i < N; i++) w[i] = mq[i];
            mq.delete();
            done = 1;
          end
        end
      end else if (sync) begin
        mq.delete();
      end
      hs = m_vld && data_ready;
      if (done && (!m_vld || hs)) begin
        m_vld = 1;
        exp_q.push_back(w);
      end else if (done) begin
        m_ovr = 1;
      end else if (hs) begin
        m_vld = 0;
      end
      if (!(done && m_vld && !hs && exp_q.size() > 0 && 0) && clr_overrun && !(done && !hs && m_vld && m_ovr_set_now(done, hs))) begin
        m_ovr = 0;
      end
    end
  end

  // True when the current edge drops a word (holder was full with no handshake).
  bit m_prev_vld;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_prev_vld <= 0;
    else          m_prev_vld <= m_vld;
  end
  function automatic bit m_ovr_set_now(input bit d, input bit h);
    return d && !h && m_prev_vld;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int hs_cnt = 0;
  int hs_cyc[$];

  always @(negedge clk) begin
    if (reset_n) begin
      chk("valid", int'(data_valid), int'(m_vld));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("busy", int'(busy), int'(mq.size() != 0));
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_word_expected", 0, 1);
        end else begin
          chk("sb_data", int'(data_out), int'(exp_q[0]));
          if (data_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            hs_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit si, input bit en, input bit sy, input bit rdy, input bit clr);
    serial_in   = si;
    shift_en    = en;
    sync        = sy;
    data_ready  = rdy;
    clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit rdy);
    for (int i = 0; i < N; i++) step(w[i], 1'b1, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int h0;
    logic [N-1:0] w;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_data", int'(data_out), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // Basic word 1,0,1,1 -> 4'b1101
    step(1, 1, 0, 0, 0);
    chk("basic_busy1", int'(busy), 1);
    step(0, 1, 0, 0, 0);
    chk("basic_busy2", int'(busy), 1);
    step(1, 1, 0, 0, 0);
    chk("basic_busy3", int'(busy), 1);
    step(1, 1, 0, 0, 0);
    chk("basic_valid", int'(data_valid), 1);
    chk("basic_data", int'(data_out), 4'b1101);
    chk("basic_busy_after", int'(busy), 0);

    // Overrun: second word 0,0,0,1 while not ready
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_data_kept", int'(data_out), 4'b1101);
    step(0, 0, 0, 0, 1);
    chk("ovr_cleared", int'(overrun), 0);
    step(0, 0, 0, 1, 0);
    chk("drain_valid", int'(data_valid), 0);

    // Streaming A, 5, F with ready held high
    h0 = hs_cnt;
    hs_cyc.delete();
    send_word(4'hA, 1'b1);
    send_word(4'h5, 1'b1);
    send_word(4'hF, 1'b1);
    step(0, 0, 0, 1, 0);
    chk("stream_count", hs_cnt - h0, 3);
    if (hs_cyc.size() == 3) begin
      chk("stream_gap1", hs_cyc[1] - hs_cyc[0], 4);
      chk("stream_gap2", hs_cyc[2] - hs_cyc[1], 4);
    end else begin
      chk("stream_hs_list", hs_cyc.size(), 3);
    end
    chk("stream_overrun", int'(overrun), 0);

    // Sync realignment: 2 stray bits, then sync on a 1, then 1,1,0
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("sync_busy", int'(busy), 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("sync_valid", int'(data_valid), 1);
    chk("sync_data", int'(data_out), 4'b0111);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("sync_partial_busy", int'(busy), 1);
    step(0, 0, 1, 0, 0);
    chk("sync_alone_busy", int'(busy), 0);

    // Reset mid-word while holding a word
    send_word(4'b1001, 1'b0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("pre_reset_valid", int'(data_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", int'(data_valid), 0);
    chk("arst_data", int'(data_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    send_word(4'b0110, 1'b0);
    chk("post_reset_valid", int'(data_valid), 1);
    chk("post_reset_data", int'(data_out), 4'b0110);

    // Completion coincides with handshake on held word
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    chk("simul_valid", int'(data_valid), 1);
    chk("simul_data", int'(data_out), 4'b0101);
    chk("simul_overrun", int'(overrun), 0);
    step(0, 0, 0, 1, 0);

    // Random traffic; the monitor compares against the model every cycle
    for (int i = 0; i < 600; i++) begin
      w = 4'($urandom_range(0, 15));
      step(w[0], bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) == 0),
           bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 9) == 0));
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Downstream companion to the team's parallel-access shift register. It consumes that register's `serial_out` bit stream, which is LSB-first because the register shifts right. It reassembles each group of N bits into a parallel word and offers the word to the next stage over a valid/ready handshake. A one-word output holding register decouples bit arrival from word consumption, and a sticky overrun flag reports any word that had to be dropped.

## Interface
Parameters:
- N, 4, word width in bits; must be 2 or greater.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial data bit, driven from the upstream `serial_out`.
- shift_en  in  1  bit strobe; `serial_in` is sampled only in cycles where this is 1.
- sync  in  1  word-alignment request; forces the bit counter to restart.
- data_out  out  N  assembled word; the first received bit appears at `data_out[0]`.
- data_valid  out  1  `data_out` holds an unconsumed word.
- data_ready  in  1  downstream accepts the word when `data_valid & data_ready`.
- overrun  out  1  sticky flag: a completed word was dropped.
- clr_overrun  in  1  synchronous clear for `overrun`.
- busy  out  1  a partial word is in progress (`bit_cnt != 0`).

## Operation
Collector state:
- Internal shift register `sr[N-1:0]` and bit counter `bit_cnt`, which counts 0..N-1.
- On `shift_en`: `sr <= {serial_in, sr[N-1:1]}` (right shift) and `bit_cnt` increments.

Word completion:
- A word completes on a `shift_en` cycle with `bit_cnt == N-1`.
- The completed word is `{serial_in, sr[N-1:1]}`.
- `bit_cnt` wraps to 0.

Alignment with `sync`:
- `sync=1` with `shift_en=1`: the current bit is bit 0 of a new word. `sr` shifts as normal and `bit_cnt` becomes 1. No word completes, even if `bit_cnt` was N-1.
- `sync=1` with `shift_en=0`: `bit_cnt` becomes 0 and the partial word is discarded.

Output side is a two-state FSM:
- EMPTY (`data_valid=0`):
  - A completed word loads `data_out` and moves to FULL.
- FULL (`data_valid=1`):
  - Handshake (`data_ready=1`) with no completion in the same cycle: move to EMPTY.
  - Completion with a handshake in the same cycle: load the new word and stay FULL (no bubble).
  - Completion without a handshake: drop the new word, set `overrun`, and leave `data_out` unchanged.

Overrun flag:
- `overrun` stays set until `clr_overrun=1`.
- If `clr_overrun` and a new overrun occur in the same cycle, `overrun` stays 1 (set wins).

Output stability:
- `data_out` is stable while `data_valid=1` and no handshake has occurred.

## Timing
- Reset values: `sr=0`, `bit_cnt=0`, `data_out=0`, `data_valid=0`, `overrun=0`, `busy=0`.
- Reset is asynchronous and takes effect immediately, including mid-word or mid-handshake. The partial word and any held word are lost.
- Latency: `data_valid` rises in the cycle after the clock edge that samples the Nth bit.
- Back-to-back words with `shift_en` held at 1 and `data_ready` held at 1: one word every N cycles, with no loss.
- All outputs are registered; there is no combinational path from input to output.
- `data_ready` is ignored while `data_valid=0`.

## Structure
Shared package `serial_rx_pkg`:
- `CNT_W = $clog2(N)`, the counter width.
- FSM state encoding: `ST_EMPTY`, `ST_FULL`.

Sub-module `bit_collector`:
- Contains `sr`, `bit_cnt` and the sync handling.
- Outputs `word_done` and `word[N-1:0]`.

Top level:
- Holding register, FSM and overrun logic.

## Test plan
Use N=4 in all scenarios.
- Basic word: reset, then `shift_en=1` for 4 cycles with `serial_in` = 1,0,1,1 and `data_ready=0`. Required: `data_out=4'b1101` and `data_valid=1` on the next cycle; `busy` is 1 during the bits and 0 after.
- Overrun: hold `data_ready=0` and send a second word, 0,0,0,1. Required: `overrun=1` and `data_out` stays `4'b1101`. Then pulse `clr_overrun`; required: `overrun=0`.
- Streaming: hold `shift_en=1` and `data_ready=1` and send the words 4'hA, 4'h5, 4'hF back to back. Required: three words accepted, 4 cycles apart, with `overrun=0` throughout.
- Sync realignment: send 2 bits, then assert `sync` with `shift_en=1` on bit 1, then send 3 more bits (1,1,0). Required: the word is `{0,1,1,1}`, i.e. `data_out=4'b0111`. Also assert `sync` alone after a partial word; required: `busy=0`.
- Reset mid-operation: deassert `reset_n` after 2 bits while `data_valid=1`. Required: all outputs go to 0 immediately, and the next 4 bits form a clean word.
- Simultaneous events: a word completes in the same cycle as a handshake on the held word. Required: the new word is loaded, `data_valid` stays 1 and `overrun` stays 0.
